deposito_rolhas: RTL and testbench



---
 rtl/deposito_rolhas.sv | 114 +++++++++++
 tb/tb_deposito_rolhas.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/deposito_rolhas.sv
// Cork magazine controller: tracks cork stock, requests refills, flags dispenser failure and underflow.
// Latency: all outputs are registered-state decodes; req follows a threshold crossing by one edge.
// Backpressure: req/ack handshake to the dispenser; ack only counts while req is high and the magazine is not full.
// Optional: define DEPOSITO_TIMEOUT_EN to build the refill timer and the FALHA (dispenser failure) state.
module deposito_rolhas #(
  parameter int CAP     = 15,
  parameter int LOW     = 5,
  parameter int W       = 4,
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ve,
  input  logic         ack,
  output logic         rolha,
  output logic         vazio,
  output logic         req,
  output logic         alarme,
  output logic         erro,
  output logic [W-1:0] cont
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] FALHA  = 2'd2;

  localparam logic [W-1:0] CAP_W = W'(CAP);
  localparam logic [W-1:0] LOW_W = W'(LOW);

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [W-1:0] cont_nxt;
  logic         inc;
  logic         dec;
  logic         full;
  logic         timeout_hit;

  assign full = (cont == CAP_W);
  assign inc  = ack & req & ~full;
  assign dec  = ve & (cont != '0);

`ifdef DEPOSITO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer;

  assign timeout_hit = (timer == TLAST) && !ack;

  // Count ack-less REFILL cycles; zero everywhere else so each REFILL entry starts fresh
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (state == REFILL && !full && !timeout_hit && !ack) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end

  assign alarme = (state == FALHA);
`else
  // Without the timer REFILL simply waits for acks forever
  assign timeout_hit = 1'b0;
  assign alarme      = 1'b0;
`endif

  // Net count change: a simultaneous valid ack and ve cancel out
  always_comb begin
    cont_nxt = cont;
    if (inc && !dec) begin
      cont_nxt = cont + 1'b1;
    end else if (dec && !inc) begin
      cont_nxt = cont - 1'b1;
    end
  end

  // Refill state machine, decided on the registered count
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cont <= LOW_W) state_nxt = REFILL;
      REFILL: begin
        if (full) begin
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          state_nxt = FALHA;
        end
      end
      FALHA:   if (ack) state_nxt = REFILL;
      default: state_nxt = IDLE;
    endcase
  end

  // State, count and sticky underflow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cont  <= '0;
      erro  <= 1'b0;
    end else begin
      state <= state_nxt;
      cont  <= cont_nxt;
      if (ve && cont == '0) begin
        erro <= 1'b1;
      end
    end
  end

  assign req   = (state != IDLE);
  assign rolha = (cont != '0);
  assign vazio = (cont == '0);

endmodule

// File: tb/tb_deposito_rolhas.sv
module tb_deposito_rolhas;

  localparam int CAP     = 15;
  localparam int LOW     = 5;
  localparam int W       = 4;
  localparam int TIMEOUT = 8;
`ifdef DEPOSITO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ve = 1'b0;
  logic         ack = 1'b0;
  logic         rolha, vazio, req, alarme, erro;
  logic [W-1:0] cont;

  deposito_rolhas #(.CAP(CAP), .LOW(LOW), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ve(ve), .ack(ack),
    .rolha(rolha), .vazio(vazio), .req(req), .alarme(alarme),
    .erro(erro), .cont(cont)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cont;
    bit rolha, vazio, req, alarme, erro;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: magazine stock plus which phase the refill dialogue is in
  typedef enum int {M_IDLE, M_REFILL, M_FALHA} mode_t;
  mode_t m_mode;
  int    m_cont;
  int    m_wait;
  bit    m_erro;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_cont = 0;
    m_wait = 0;
    m_erro = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit a);
    bit asking, got, used;
    asking = (m_mode != M_IDLE);
    got    = a && asking && (m_cont < CAP);
    used   = v && (m_cont > 0);
    if (v && m_cont == 0) m_erro = 1'b1;
    case (m_mode)
      M_IDLE: if (m_cont <= LOW) begin m_mode = M_REFILL; m_wait = 0; end
      M_REFILL: begin
        if (m_cont == CAP) m_mode = M_IDLE;
        else if (TO_EN && !a && m_wait == TIMEOUT - 1) m_mode = M_FALHA;
        else if (a) m_wait = 0;
        else m_wait = m_wait + 1;
      end
      M_FALHA: if (a) begin m_mode = M_REFILL; m_wait = 0; end
      default: m_mode = M_IDLE;
    endcase
    m_cont = m_cont + int'(got) - int'(used);
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.cont   = m_cont;
    e.rolha  = (m_cont != 0);
    e.vazio  = (m_cont == 0);
    e.req    = (m_mode != M_IDLE);
    e.alarme = (m_mode == M_FALHA);
    e.erro   = m_erro;
    return e;
  endfunction

  // Drive inputs for the coming edge and queue what the DUT must show after it
  task automatic set_and_push(input bit v, input bit a);
    ve  = v;
    ack = a;
    model_step(v, a);
    q.push_back(model_outputs());
  endtask

  task automatic cycle(input bit v, input bit a);
    @(negedge clk);
    set_and_push(v, a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cont"},   32'(cont),   0);
    check({tag, "_rolha"},  32'(rolha),  0);
    check({tag, "_vazio"},  32'(vazio),  1);
    check({tag, "_req"},    32'(req),    0);
    check({tag, "_alarme"}, 32'(alarme), 0);
    check({tag, "_erro"},   32'(erro),   0);
  endtask

  // Asynchronous reset between edges, after the monitor has sampled the last edge
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    ve    = 1'b0;
    ack   = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_outputs(tag);
  endtask

  task automatic release_reset(input bit v, input bit a);
    @(negedge clk);
    reset = 1'b1;
    set_and_push(v, a);
  endtask

  // Monitor: every edge out of reset must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset && q.size() > 0) begin
        e = q.pop_front();
        check("cont",   32'(cont),   32'(e.cont));
        check("rolha",  32'(rolha),  32'(e.rolha));
        check("vazio",  32'(vazio),  32'(e.vazio));
        check("req",    32'(req),    32'(e.req));
        check("alarme", 32'(alarme), 32'(e.alarme));
        check("erro",   32'(erro),   32'(e.erro));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int pct;
    model_reset();
    #12;
    check_reset_outputs("reset");

    // Fill from empty with ack held high
    release_reset(1'b0, 1'b1);
    repeat (16) cycle(1'b0, 1'b1);

    // Consume down to the threshold, then one quiet edge for req to rise
    repeat (10) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);

    // Two acks to reach 7, then simultaneous ve and ack
    repeat (2) cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b1, 1'b1);

    // Dispenser goes silent long enough to time out, then one ack recovers
    repeat (10) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);

    // Drain past empty to provoke underflow, then refill; erro must stick
    repeat (11) cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b1);

    // Random traffic with varying dispenser reliability
    for (int blk = 0; blk < 25; blk++) begin
      case ($urandom_range(0, 3))
        0:       pct = 0;
        1:       pct = 25;
        2:       pct = 75;
        default: pct = 100;
      endcase
      for (int i = 0; i < 16; i++) begin
        cycle($urandom_range(0, 2) == 0, $urandom_range(1, 100) <= pct);
      end
    end

    // Reset from whatever random state is current (erro is set by now)
    async_reset("rst_after_random");

    // Refill up to 9 then reset in the middle of REFILL
    release_reset(1'b0, 1'b1);
    repeat (9) cycle(1'b0, 1'b1);
    async_reset("rst_mid_refill");

    // A few edges after release to confirm restart behaviour
    release_reset(1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1);

    @(posedge clk);
    #3;
    check("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
